// File: rtl/affine_addr_gen_pkg.sv
// Package: affine_addr_gen_pkg
// Shared types and default parameter values for the affine address generator.
//   state_t : controller states
//   cfg_t   : per-job configuration record at the default widths
package affine_addr_gen_pkg;

  localparam int DEF_NDIM     = 3;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_STRIDE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Element [d] belongs to loop dimension d; dimension 0 is innermost.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]                    base;
    logic [DEF_NDIM-1:0][DEF_CNT_W-1:0]       extent;
    logic [DEF_NDIM-1:0][DEF_STRIDE_W-1:0]    stride;
  } cfg_t;

endpackage

// File: rtl/affine_addr_gen_addr_dim_counter.sv
// Module: addr_dim_counter
// One loop dimension: an index counter plus its running offset
// (idx * stride accumulated incrementally, so no multiplier is needed).
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clr_i          job start: idx and offset to zero (wins over step_i)
//   step_i         advance this dimension by one
//   extent_i       inclusive maximum index
//   stride_i       signed stride, sign-extended into the offset
//   at_max_o       idx is at extent
//   off_o          current offset, ADDR_W wide, wraps modulo 2^ADDR_W
module addr_dim_counter #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter int STRIDE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                step_i,
  input  logic [CNT_W-1:0]    extent_i,
  input  logic [STRIDE_W-1:0] stride_i,
  output logic                at_max_o,
  output logic [ADDR_W-1:0]   off_o
);

  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] off_q, off_d;

  assign at_max_o = (idx_q == extent_i);
  assign off_o    = off_q;

  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    if (clr_i) begin
      idx_d = '0;
      off_d = '0;
    end else if (step_i) begin
      if (at_max_o) begin
        idx_d = '0;
        off_d = '0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
        off_d = off_q + ADDR_W'(signed'(stride_i));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      off_q <= '0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/affine_addr_gen.sv
// Module: affine_addr_gen
// N-dimensional affine address generator. Streams
//   addr = base + sum_d(idx[d] * stride[d])
// in lexicographic order (dim 0 innermost) over a valid/ready port.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   start_i                begin a job (IDLE only); latches base/extent/stride
//   abort_i                cancel the running job, no done pulse
//   base_i                 job base address
//   extent_i               per-dim inclusive max index, dim d at [d*CNT_W +: CNT_W]
//   stride_i               per-dim signed stride, dim d at [d*STRIDE_W +: STRIDE_W]
//   addr_valid_o/ready_i   output handshake
//   addr_o, addr_last_o    current beat and final-beat flag
//   busy_o                 job running
//   done_o                 one-cycle pulse after the final beat is accepted
module affine_addr_gen
  import affine_addr_gen_pkg::*;
#(
  parameter int NDIM     = DEF_NDIM,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STRIDE_W = DEF_STRIDE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [ADDR_W-1:0]        base_i,
  input  logic [NDIM*CNT_W-1:0]    extent_i,
  input  logic [NDIM*STRIDE_W-1:0] stride_i,
  output logic                     addr_valid_o,
  input  logic                     addr_ready_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     addr_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  // Same layout as cfg_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]                base;
    logic [NDIM-1:0][CNT_W-1:0]       extent;
    logic [NDIM-1:0][STRIDE_W-1:0]    stride;
  } job_cfg_t;

  state_t   state_q, state_d;
  job_cfg_t cfg_q, cfg_d;
  logic     done_q, done_d;
  logic     load, adv, hs, carry;

  logic [NDIM-1:0]             at_max, wrap, step;
  logic [NDIM-1:0][ADDR_W-1:0] off;
  logic [ADDR_W-1:0]           addr_sum;

  assign addr_valid_o = (state_q == RUN);
  assign busy_o       = (state_q == RUN);
  assign done_o       = done_q;
  assign hs           = addr_valid_o & addr_ready_i;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        // abort outranks a same-cycle handshake: that beat is dropped
        if (abort_i) begin
          state_d = IDLE;
        end else if (hs) begin
          adv = 1'b1;
          if (wrap[NDIM-1]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_d = cfg_q;
    if (load) begin
      cfg_d.base   = base_i;
      cfg_d.extent = extent_i;
      cfg_d.stride = stride_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  // wrap[d]: dims 0..d all sit at their extent, so dim d+1 must carry.
  always_comb begin
    wrap  = '0;
    carry = 1'b1;
    for (int d = 0; d < NDIM; d++) begin
      carry   = carry & at_max[d];
      wrap[d] = carry;
    end
  end

  for (genvar d = 0; d < NDIM; d++) begin : g_dim
    if (d == 0) begin : g_inner
      assign step[d] = adv;
    end else begin : g_outer
      assign step[d] = adv & wrap[d-1];
    end

    addr_dim_counter #(
      .ADDR_W   (ADDR_W),
      .CNT_W    (CNT_W),
      .STRIDE_W (STRIDE_W)
    ) u_dim (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (load),
      .step_i   (step[d]),
      .extent_i (cfg_q.extent[d]),
      .stride_i (cfg_q.stride[d]),
      .at_max_o (at_max[d]),
      .off_o    (off[d])
    );
  end

  always_comb begin
    addr_sum = cfg_q.base;
    for (int d = 0; d < NDIM; d++) begin
      addr_sum = addr_sum + off[d];
    end
  end

  // Only registered state feeds these, so backpressure cannot disturb them.
  assign addr_o      = addr_valid_o ? addr_sum : '0;
  assign addr_last_o = addr_valid_o & wrap[NDIM-1];

endmodule

// File: tb/tb_affine_addr_gen.sv
module tb_affine_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base;
  logic [47:0] extent;
  logic [47:0] stride;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic        addr_last;
  logic        busy;
  logic        done;

  affine_addr_gen dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .base_i       (base),
    .extent_i     (extent),
    .stride_i     (stride),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .addr_o       (addr),
    .addr_last_o  (addr_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        last;
  } sb_t;

  typedef struct {
    logic [31:0]       base;
    logic [2:0][15:0]  ext;
    logic [2:0][15:0]  str;
    int                n;          // 0: expectations come from the loop model
    logic [7:0][31:0]  exp;
    int                stall_beat; // -1: never stall
    int                bstart_beat;// -1: no start while busy
    bit                abort_w_start;
  } vec_t;

  sb_t  exp_q[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  int   beats_seen = 0;
  int   done_cnt = 0;
  logic prev_last_hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard consumer: one entry per accepted beat.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && addr_valid && addr_ready && !abort) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got addr 0x%h, expected no beat at %0t", addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_addr", addr, e.addr);
        chk("beat_last", {31'b0, addr_last}, {31'b0, e.last});
        beats_seen++;
      end
    end
    if (done || prev_last_hs) chk("done_timing", {31'b0, done}, {31'b0, prev_last_hs});
    if (done) done_cnt++;
    prev_last_hs = rst_n && addr_valid && addr_ready && !abort && addr_last;
  end

  // Independent nested-loop model, dim 0 innermost.
  task automatic push_exp(input vec_t v);
    logic [31:0] a;
    if (v.n > 0) begin
      for (int i = 0; i < v.n; i++) exp_q.push_back({v.exp[i], (i == v.n - 1)});
    end else begin
      for (int i2 = 0; i2 <= int'(v.ext[2]); i2++)
        for (int i1 = 0; i1 <= int'(v.ext[1]); i1++)
          for (int i0 = 0; i0 <= int'(v.ext[0]); i0++) begin
            a = v.base + 32'(i0) * 32'(signed'(v.str[0]))
                       + 32'(i1) * 32'(signed'(v.str[1]))
                       + 32'(i2) * 32'(signed'(v.str[2]));
            exp_q.push_back({a, (i0 == int'(v.ext[0]) && i1 == int'(v.ext[1]) && i2 == int'(v.ext[2]))});
          end
    end
  endtask

  task automatic start_job(input vec_t v, input bit with_abort);
    @(posedge clk); #1;
    start  = 1'b1;
    abort  = with_abort;
    base   = v.base;
    extent = v.ext;
    stride = v.str;
    @(posedge clk); #1;
    start  = 1'b0;
    abort  = 1'b0;
    base   = $urandom;
    extent = {$urandom, $urandom};
    stride = {$urandom, $urandom};
  endtask

  task automatic do_job(input string tag, input vec_t v);
    int cyc;
    int stall_left;
    done_cnt   = 0;
    beats_seen = 0;
    addr_ready = 1'b1;
    push_exp(v);
    start_job(v, v.abort_w_start);
    chk({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
    chk({tag, "_first_addr"}, addr, v.base);
    stall_left = 3;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      addr_ready = 1'b1;
      if (v.stall_beat == beats_seen && stall_left > 0) begin
        addr_ready = 1'b0;
        stall_left--;
      end
      if (v.bstart_beat == beats_seen) begin
        start = 1'b1;
        base  = 32'hDEAD0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (!addr_ready && exp_q.size() > 0) begin
        chk({tag, "_stall_addr"}, addr, exp_q[0].addr);
        chk({tag, "_stall_valid"}, {31'b0, addr_valid}, 32'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b1;
    if (cyc >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, done_cnt, 32'd1);
    chk({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
    chk({tag, "_valid_off"}, {31'b0, addr_valid}, 32'd0);
  endtask

  initial begin
    int cyc;
    vec_t v;

    tbl[0].base = 32'h100;
    tbl[0].ext  = {16'd0, 16'd1, 16'd3};
    tbl[0].str  = {16'd0, 16'd16, 16'd1};
    tbl[0].n    = 8;
    tbl[0].exp  = {32'h113, 32'h112, 32'h111, 32'h110, 32'h103, 32'h102, 32'h101, 32'h100};
    tbl[0].stall_beat = -1;
    tbl[0].bstart_beat = -1;
    tbl[0].abort_w_start = 1'b0;

    tbl[1] = tbl[0];
    tbl[1].stall_beat = 2;

    tbl[2].base = 32'h40;
    tbl[2].ext  = {16'd1, 16'd1, 16'd1};
    tbl[2].str  = {16'h0100, 16'hFFF8, 16'h0004};
    tbl[2].n    = 8;
    tbl[2].exp  = {32'h13C, 32'h138, 32'h144, 32'h140, 32'h3C, 32'h38, 32'h44, 32'h40};
    tbl[2].stall_beat = -1;
    tbl[2].bstart_beat = 3;
    tbl[2].abort_w_start = 1'b0;

    tbl[3].base = 32'h1234;
    tbl[3].ext  = '0;
    tbl[3].str  = {16'd7, 16'd6, 16'd5};
    tbl[3].n    = 1;
    tbl[3].exp  = '0;
    tbl[3].exp[0] = 32'h1234;
    tbl[3].stall_beat = -1;
    tbl[3].bstart_beat = -1;
    tbl[3].abort_w_start = 1'b1;

    tbl[4].base = 32'hFFFF_FFFE;
    tbl[4].ext  = {16'd0, 16'd0, 16'd3};
    tbl[4].str  = {16'd0, 16'd0, 16'd1};
    tbl[4].n    = 4;
    tbl[4].exp  = '0;
    tbl[4].exp[0] = 32'hFFFF_FFFE;
    tbl[4].exp[1] = 32'hFFFF_FFFF;
    tbl[4].exp[2] = 32'h0000_0000;
    tbl[4].exp[3] = 32'h0000_0001;
    tbl[4].stall_beat = -1;
    tbl[4].bstart_beat = -1;
    tbl[4].abort_w_start = 1'b0;

    tbl[5].base = 32'h2000;
    tbl[5].ext  = {16'd1, 16'd3, 16'd2};
    tbl[5].str  = {16'h0040, 16'hFFFB, 16'd3};
    tbl[5].n    = 0;
    tbl[5].exp  = '0;
    tbl[5].stall_beat = 5;
    tbl[5].bstart_beat = -1;
    tbl[5].abort_w_start = 1'b0;

    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base = '0;
    extent = '0;
    stride = '0;
    addr_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, addr_valid}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_last", {31'b0, addr_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_job($sformatf("job%0d", i), tbl[i]);

    // Abort on the cycle of the third handshake: that beat is dropped.
    v = tbl[0];
    done_cnt = 0;
    beats_seen = 0;
    exp_q.push_back({32'h100, 1'b0});
    exp_q.push_back({32'h101, 1'b0});
    start_job(v, 1'b0);
    cyc = 0;
    while (beats_seen < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reach_beat2", beats_seen, 32'd2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", {31'b0, addr_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_sb_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    do_job("after_abort", tbl[0]);

    // Reset in the middle of a job.
    done_cnt = 0;
    beats_seen = 0;
    push_exp(tbl[2]);
    start_job(tbl[2], 1'b0);
    cyc = 0;
    while (beats_seen < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst_reach_beat3", beats_seen, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, addr_valid}, 32'd0);
    chk("midrst_addr", addr, 32'd0);
    chk("midrst_last", {31'b0, addr_last}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 32'd0);
    do_job("after_reset", tbl[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
